// File: rtl/vend_dispense_ctrl.sv
// Newspaper vending sequencer: accumulates coin credit, handshakes one vend with
// the dispenser, then refunds any remaining credit as nickels via the change hopper.
module vend_dispense_ctrl #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 100,
    parameter int CREDIT_W   = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                change_ack,
    output logic                disp_req,
    output logic                change_req,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int SUM_W = CREDIT_W + 1;

    localparam logic [SUM_W-1:0]    MAX_EXT   = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]    PRICE_EXT = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic                reject_next;
    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    credit_sum;
    logic [CREDIT_W-1:0] credit_after_vend;
    logic                coin_present;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = SUM_W'(5);
            2'b10:   coin_val = SUM_W'(10);
            2'b11:   coin_val = SUM_W'(25);
            default: coin_val = '0;
        endcase
    end

    // One extra bit so credit plus a quarter cannot wrap before the overflow test.
    assign credit_sum        = {1'b0, credit} + coin_val;
    assign credit_after_vend = credit - PRICE_C;
    assign coin_present      = (coin != 2'b00);

    always_comb begin
        state_next  = state;
        credit_next = credit;
        reject_next = 1'b0;

        case (state)
            IDLE: begin
                if (cancel) begin
                    reject_next = coin_present;
                    if (credit != '0) begin
                        state_next = CHANGE;
                    end
                end else if (coin_present) begin
                    if (credit_sum > MAX_EXT) begin
                        reject_next = 1'b1;
                    end else begin
                        credit_next = credit_sum[CREDIT_W-1:0];
                        if (credit_sum >= PRICE_EXT) begin
                            state_next = DISPENSE;
                        end
                    end
                end
            end

            DISPENSE: begin
                reject_next = coin_present;
                if (disp_ack) begin
                    credit_next = credit_after_vend;
                    state_next  = (credit_after_vend != '0) ? CHANGE : IDLE;
                end
            end

            CHANGE: begin
                reject_next = coin_present;
                if (change_ack) begin
                    // Credit is always a multiple of 5 here; clamp keeps it from underflowing.
                    if (credit <= NICKEL_C) begin
                        credit_next = '0;
                        state_next  = IDLE;
                    end else begin
                        credit_next = credit - NICKEL_C;
                    end
                end
            end

            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            coin_reject <= reject_next;
        end
    end

    assign disp_req   = (state == DISPENSE);
    assign change_req = (state == CHANGE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench: directed vector tables on two price configurations plus
// randomized traffic checked against a credit/obligation reference model.
module tb_vend_dispense_ctrl;

    localparam int CW = 7;

    typedef struct {
        logic          rst;
        logic [1:0]    coin;
        logic          cancel;
        logic          dack;
        logic          cack;
        int            exp_credit;
        logic          exp_dreq;
        logic          exp_creq;
        logic          exp_rej;
        logic          exp_busy;
        string         name;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          a_reset, a_cancel, a_dack, a_cack;
    logic [1:0]    a_coin;
    logic          a_dreq, a_creq, a_rej, a_busy;
    logic [CW-1:0] a_credit;

    logic          b_reset, b_cancel, b_dack, b_cack;
    logic [1:0]    b_coin;
    logic          b_dreq, b_creq, b_rej, b_busy;
    logic [CW-1:0] b_credit;

    vend_dispense_ctrl #(.PRICE(15), .MAX_CREDIT(100), .CREDIT_W(CW)) dut_a (
        .clock(clock), .reset(a_reset), .coin(a_coin), .cancel(a_cancel),
        .disp_ack(a_dack), .change_ack(a_cack), .disp_req(a_dreq),
        .change_req(a_creq), .coin_reject(a_rej), .credit(a_credit), .busy(a_busy)
    );

    vend_dispense_ctrl #(.PRICE(100), .MAX_CREDIT(100), .CREDIT_W(CW)) dut_b (
        .clock(clock), .reset(b_reset), .coin(b_coin), .cancel(b_cancel),
        .disp_ack(b_dack), .change_ack(b_cack), .disp_req(b_dreq),
        .change_req(b_creq), .coin_reject(b_rej), .credit(b_credit), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] coin, input logic cancel,
                                input logic dack, input logic cack, input int cr,
                                input logic dreq, input logic creq, input logic rej,
                                input logic busy, input string name);
        vec_t v;
        v.rst = rst; v.coin = coin; v.cancel = cancel; v.dack = dack; v.cack = cack;
        v.exp_credit = cr; v.exp_dreq = dreq; v.exp_creq = creq;
        v.exp_rej = rej; v.exp_busy = busy; v.name = name;
        return v;
    endfunction

    task automatic compare(input string name, input int cr, input logic dreq, input logic creq,
                           input logic rej, input logic busy, input int ecr, input logic edreq,
                           input logic ecreq, input logic erej, input logic ebusy);
        checks++;
        if (cr != ecr || dreq !== edreq || creq !== ecreq || rej !== erej || busy !== ebusy) begin
            errors++;
            $display("FAIL %s: got credit=%0d disp_req=%b change_req=%b coin_reject=%b busy=%b, expected credit=%0d disp_req=%b change_req=%b coin_reject=%b busy=%b",
                     name, cr, dreq, creq, rej, busy, ecr, edreq, ecreq, erej, ebusy);
        end
    endtask

    task automatic apply_a(input vec_t v);
        a_reset = v.rst; a_coin = v.coin; a_cancel = v.cancel; a_dack = v.dack; a_cack = v.cack;
        @(posedge clock); #1;
        compare(v.name, int'(a_credit), a_dreq, a_creq, a_rej, a_busy,
                v.exp_credit, v.exp_dreq, v.exp_creq, v.exp_rej, v.exp_busy);
    endtask

    task automatic apply_b(input vec_t v);
        b_reset = v.rst; b_coin = v.coin; b_cancel = v.cancel; b_dack = v.dack; b_cack = v.cack;
        @(posedge clock); #1;
        compare(v.name, int'(b_credit), b_dreq, b_creq, b_rej, b_busy,
                v.exp_credit, v.exp_dreq, v.exp_creq, v.exp_rej, v.exp_busy);
    endtask

    // Reference model: credit in cents plus two obligations (an item owed, a refund owed).
    int m_credit;
    bit m_item_owed;
    bit m_refund_owed;
    bit m_rej;

    function automatic int coin_cents(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic [1:0] coin, input logic cancel,
                              input logic dack, input logic cack, input int price, input int max_cr);
        int v;
        v = coin_cents(coin);
        m_rej = 1'b0;
        if (rst) begin
            m_credit = 0; m_item_owed = 0; m_refund_owed = 0;
        end else if (m_item_owed || m_refund_owed) begin
            m_rej = (v != 0);
            if (m_item_owed && dack) begin
                m_credit    = m_credit - price;
                m_item_owed = 0;
                m_refund_owed = (m_credit > 0);
            end else if (m_refund_owed && cack) begin
                m_credit = m_credit - 5;
                if (m_credit == 0) m_refund_owed = 0;
            end
        end else if (cancel) begin
            m_rej = (v != 0);
            if (m_credit > 0) m_refund_owed = 1;
        end else if (v != 0) begin
            if (m_credit + v > max_cr) m_rej = 1'b1;
            else begin
                m_credit = m_credit + v;
                if (m_credit >= price) m_item_owed = 1;
            end
        end
    endtask

    initial begin
        a_reset = 1; a_coin = 0; a_cancel = 0; a_dack = 0; a_cack = 0;
        b_reset = 1; b_coin = 0; b_cancel = 0; b_dack = 0; b_cack = 0;

        //                 rst coin  can dk ck  cr dreq creq rej busy
        vecs_a.push_back(mk(1, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, "reset"));
        vecs_a.push_back(mk(0, 2'b01, 0, 0, 0,  5, 0, 0, 0, 0, "n1"));
        vecs_a.push_back(mk(0, 2'b01, 0, 0, 0, 10, 0, 0, 0, 0, "n2"));
        vecs_a.push_back(mk(0, 2'b01, 0, 0, 0, 15, 1, 0, 0, 1, "n3_disp"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 0, 15, 1, 0, 0, 1, "n_wait1"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 0, 15, 1, 0, 0, 1, "n_wait2"));
        vecs_a.push_back(mk(0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, "n_vend_idle"));
        vecs_a.push_back(mk(0, 2'b00, 0, 1, 1,  0, 0, 0, 0, 0, "stray_acks"));
        vecs_a.push_back(mk(0, 2'b11, 0, 0, 1, 25, 1, 0, 0, 1, "q_disp"));
        vecs_a.push_back(mk(0, 2'b00, 0, 1, 1, 10, 0, 1, 0, 1, "q_vend"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 1,  5, 0, 1, 0, 1, "q_chg1"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, "q_chg2"));
        vecs_a.push_back(mk(0, 2'b10, 0, 0, 0, 10, 0, 0, 0, 0, "c_dime"));
        vecs_a.push_back(mk(0, 2'b01, 1, 0, 0, 10, 0, 1, 1, 1, "c_cancel_coin"));
        vecs_a.push_back(mk(0, 2'b00, 1, 0, 1,  5, 0, 1, 0, 1, "c_chg1"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, "c_chg2"));
        vecs_a.push_back(mk(0, 2'b10, 1, 0, 0,  0, 0, 0, 1, 0, "cancel0_rej1"));
        vecs_a.push_back(mk(0, 2'b11, 1, 0, 0,  0, 0, 0, 1, 0, "cancel0_rej2"));
        vecs_a.push_back(mk(0, 2'b00, 1, 0, 0,  0, 0, 0, 0, 0, "cancel0_none"));
        vecs_a.push_back(mk(0, 2'b10, 0, 0, 0, 10, 0, 0, 0, 0, "b_dime"));
        vecs_a.push_back(mk(0, 2'b01, 0, 0, 0, 15, 1, 0, 0, 1, "b_disp"));
        vecs_a.push_back(mk(0, 2'b11, 0, 0, 0, 15, 1, 0, 1, 1, "b_busy_rej"));
        vecs_a.push_back(mk(0, 2'b00, 1, 0, 0, 15, 1, 0, 0, 1, "b_hold1"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 0, 15, 1, 0, 0, 1, "b_hold2"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 0, 15, 1, 0, 0, 1, "b_hold3"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 0, 15, 1, 0, 0, 1, "b_hold4"));
        vecs_a.push_back(mk(0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, "b_vend"));
        vecs_a.push_back(mk(0, 2'b01, 0, 0, 0,  5, 0, 0, 0, 0, "r_nickel"));
        vecs_a.push_back(mk(0, 2'b11, 0, 0, 0, 30, 1, 0, 0, 1, "r_quarter"));
        vecs_a.push_back(mk(0, 2'b00, 0, 1, 0, 15, 0, 1, 0, 1, "r_vend"));
        vecs_a.push_back(mk(0, 2'b01, 0, 0, 0, 15, 0, 1, 1, 1, "r_chg_rej"));
        vecs_a.push_back(mk(1, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, "r_reset_chg"));
        vecs_a.push_back(mk(0, 2'b00, 0, 0, 1,  0, 0, 0, 0, 0, "r_stuck_ack"));

        vecs_b.push_back(mk(1, 2'b00, 0, 0, 0,   0, 0, 0, 0, 0, "p100_reset"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  25, 0, 0, 0, 0, "p100_q1"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  50, 0, 0, 0, 0, "p100_q2"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  75, 0, 0, 0, 0, "p100_q3"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0, 100, 1, 0, 0, 1, "p100_q4"));
        vecs_b.push_back(mk(0, 2'b01, 0, 0, 0, 100, 1, 0, 1, 1, "p100_nickel_rej"));
        vecs_b.push_back(mk(0, 2'b00, 0, 1, 0,   0, 0, 0, 0, 0, "p100_vend"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  25, 0, 0, 0, 0, "p100_s1"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  50, 0, 0, 0, 0, "p100_s2"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  75, 0, 0, 0, 0, "p100_s3"));
        vecs_b.push_back(mk(0, 2'b10, 0, 0, 0,  85, 0, 0, 0, 0, "p100_s4"));
        vecs_b.push_back(mk(0, 2'b01, 0, 0, 0,  90, 0, 0, 0, 0, "p100_s5"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  90, 0, 0, 1, 0, "p100_overflow"));
        vecs_b.push_back(mk(0, 2'b11, 0, 0, 0,  90, 0, 0, 1, 0, "p100_overflow2"));
        vecs_b.push_back(mk(0, 2'b10, 0, 0, 0, 100, 1, 0, 0, 1, "p100_exact"));

        @(posedge clock); #1;
        foreach (vecs_a[i]) apply_a(vecs_a[i]);
        foreach (vecs_b[i]) apply_b(vecs_b[i]);

        // Randomized traffic on the PRICE=15 instance against the reference model.
        m_credit = 0; m_item_owed = 0; m_refund_owed = 0; m_rej = 0;
        apply_a(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, "rand_reset"));
        for (int n = 0; n < 3000; n++) begin
            logic       r, ca, dk, ck;
            logic [1:0] c;
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
            ca = ($urandom_range(0, 15) == 0);
            dk = ($urandom_range(0, 2) == 0);
            ck = ($urandom_range(0, 1) == 0);
            model_step(r, c, ca, dk, ck, 15, 100);
            apply_a(mk(r, c, ca, dk, ck, m_credit, m_item_owed, m_refund_owed, m_rej,
                       m_item_owed | m_refund_owed, "rand"));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Sequencing controller for the newspaper vending machine.
- Accepts coin codes from the coin slot and accumulates credit.
- When credit reaches the price, runs a req/ack handshake with the dispenser mechanism, then pays out remaining credit as nickels via a req/ack handshake with the change hopper.
- Supports customer cancel (full refund) and rejects coins that arrive while the machine is busy or that would overflow credit.

Parameters:
- PRICE, 15, item price in cents; must be a nonzero multiple of 5 and <= MAX_CREDIT.
- MAX_CREDIT, 100, highest credit held in cents; must be a multiple of 5 and < 2**CREDIT_W.
- CREDIT_W, 7, width of the credit register and output.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- coin  input  2  per-cycle coin code: 00 none, 01 nickel (5), 10 dime (10), 11 quarter (25).
- cancel  input  1  level, sampled each cycle; refund request.
- disp_ack  input  1  dispenser completed one item.
- change_ack  input  1  hopper ejected one nickel.
- disp_req  output  1  request dispenser to vend one item.
- change_req  output  1  request hopper to eject one nickel.
- coin_reject  output  1  one-cycle pulse: the coin sampled last cycle is routed to the return chute.
- credit  output  CREDIT_W  current credit in cents.
- busy  output  1  high in DISPENSE or CHANGE.

Behaviour:
- States: IDLE, DISPENSE, CHANGE. Registered state; disp_req = (state==DISPENSE), change_req = (state==CHANGE), busy = (state!=IDLE). All three are pure state decodes.
- Reset: state IDLE, credit 0, coin_reject 0, disp_req 0, change_req 0, busy 0. Reset overrides every other input in the same cycle, including mid-handshake (the request drops the next cycle; the in-flight ack is ignored).

IDLE:
- cancel=1 and credit>0: next state CHANGE.
- cancel=1 with coin!=00 in the same cycle: cancel wins; the coin is rejected (coin_reject=1 next cycle), credit unchanged.
- cancel=1 and credit==0: no action; any coin that cycle is rejected.
- Otherwise, coin!=00 with value v:
  - credit+v > MAX_CREDIT: coin_reject pulses next cycle, credit unchanged.
  - else credit <= credit+v in the same edge; if credit+v >= PRICE, next state is DISPENSE.
- Latency: coin sampled at edge N gives credit updated and disp_req high from cycle N+1.

DISPENSE:
- disp_req held high until disp_ack is sampled high.
- On that edge: credit <= credit-PRICE; next state CHANGE if the result > 0, else IDLE.
- disp_ack outside DISPENSE is ignored.

CHANGE:
- change_req held high; each edge with change_ack=1 does credit <= credit-5.
- The ack taken at credit==5 makes credit 0, next state IDLE, and change_req low the next cycle.
- change_ack outside CHANGE is ignored.
- Only one item is vended per purchase. Excess credit after the vend is always refunded, never held for a second item.

Busy conditions:
- Any coin!=00 while in DISPENSE or CHANGE is rejected (coin_reject pulse next cycle, credit unchanged).
- cancel is ignored while in DISPENSE or CHANGE.

Arithmetic:
- Unsigned, CREDIT_W bits.
- The overflow compare uses CREDIT_W+1 bits so that credit+25 cannot wrap.
- credit never goes below 0 and never exceeds MAX_CREDIT.
- coin_reject is exactly one cycle per rejected coin; back-to-back rejected coins give consecutive pulses.

Test Plan:
- Reset then nickel, nickel, nickel (one per cycle), disp_ack 2 cycles after disp_req rises -> credit 5, 10, 15; disp_req high from the cycle after the 3rd coin for 3 cycles; credit 0; back to IDLE; change_req never asserted.
- Quarter with PRICE=15, disp_ack after 1 cycle, change_ack held high -> credit 25, then 10 after vend; change_req high for exactly 2 cycles; credit 5 then 0; busy low after.
- Dime, then cancel together with a nickel in the same cycle -> nickel rejected (coin_reject one pulse); credit stays 10; CHANGE; 2 change_acks return credit to 0; disp_req never asserted.
- Quarter inserted during DISPENSE with disp_ack withheld 5 cycles -> coin_reject pulses once; credit unchanged; vend completes normally.
- PRICE=100: four quarters then a nickel -> first four accepted up to credit 100, DISPENSE entered; the nickel arriving in DISPENSE is rejected. Separately, PRICE=100 with credit 90 plus a quarter -> coin_reject pulses, credit stays 90.
- reset asserted in CHANGE with credit 15 and change_ack stuck high -> next cycle IDLE, credit 0, change_req 0, no further decrement.
